// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Holds the Gray phase encoding, direction constants, decoder state and
// the forward-order helper used by both the design and its bench.
package quad_decoder_pkg;

  // Phase pair {a,b}; forward (up) order is 00 -> 01 -> 11 -> 10 -> 00.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Decoder lifecycle: wait for the first trustworthy phase pair, then track.
  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Classification of one phase transition.
  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    MOVE_FWD  = 2'd1,
    MOVE_REV  = 2'd2,
    MOVE_BAD  = 2'd3
  } move_t;

  // Successor of a phase in the forward (counting up) direction.
  function automatic phase_t next_fwd(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // A step is forward if cur follows prev, reverse if prev follows cur;
  // any other change flips both bits and is illegal.
  function automatic move_t classify(input phase_t prev, input phase_t cur);
    if (cur == prev)                return MOVE_NONE;
    else if (cur == next_fwd(prev)) return MOVE_FWD;
    else if (prev == next_fwd(cur)) return MOVE_REV;
    else                            return MOVE_BAD;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Bus between the encoder-facing decoder and its controller.
// The controller side (master) drives the raw phases and control strobes;
// the decoder side (slave) returns position, direction, step and error.
interface quad_decoder_if #(
  parameter int WIDTH = 16
);

  logic             a_in;
  logic             b_in;
  logic             en;
  logic             clr;
  logic             err_clr;
  logic [WIDTH-1:0] count;
  logic             up;
  logic             step;
  logic             err;

  modport master (
    output a_in, b_in, en, clr, err_clr,
    input  count, up, step, err
  );

  modport slave (
    input  a_in, b_in, en, clr, err_clr,
    output count, up, step, err
  );

endinterface

// File: rtl/quad_input_cond.sv
// Conditioning for one encoder phase: 2-FF synchroniser, followed by a
// stability filter when QUAD_DECODER_FILTER_EN is defined.
// `valid` rises once `phase` reflects a real sample of the pin rather than
// the reset value of the pipeline, so the decoder never primes on stale data.
module quad_input_cond #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic phase,
  output logic valid
);

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("quad_input_cond: FILT_LEN must be within 2..15");
  end

`ifdef QUAD_DECODER_FILTER_EN
  // Sync stages plus the FILT_LEN-1 history stages must hold real samples.
  localparam int WARM_LEN = FILT_LEN + 1;
`else
  localparam int WARM_LEN = 2;
`endif

  logic [1:0]          sync_q;   // [0] first stage, [1] synchronised bit
  logic [WARM_LEN-1:0] warm_q;   // fills with ones as the pipeline fills

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking here so both stages sample pre-edge values;
      // a blocking assignment would collapse the chain into one flop.
      sync_q <= {sync_q[0], raw};
    end
  end

  // Pipeline-fill tracker: msb is set once every stage holds a real sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_q <= '0;
    end else begin
      warm_q <= {warm_q[WARM_LEN-2:0], 1'b1};
    end
  end

`ifdef QUAD_DECODER_FILTER_EN

  logic [FILT_LEN-2:0] hist_q;   // previous FILT_LEN-1 synchronised samples
  logic                held_q;   // last accepted value
  logic                seen_q;   // a value has been accepted since reset
  logic                stable;

  // Accept the synchronised bit once it matches all FILT_LEN-1 prior samples;
  // this combinational bypass keeps the added latency at FILT_LEN-1 edges.
  always_comb begin
    stable = (hist_q == {(FILT_LEN-1){sync_q[1]}});
    phase  = stable ? sync_q[1] : held_q;
    valid  = warm_q[WARM_LEN-1] & (seen_q | stable);
  end

  // History shift register and hold of the accepted value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the history is reset like any other flop; left unreset it
      // could read as "stable" on garbage and be accepted after reset.
      hist_q <= '0;
      held_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      hist_q[0] <= sync_q[1];
      for (int i = 1; i < FILT_LEN - 1; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      held_q <= phase;
      seen_q <= valid;
    end
  end

`else

  // Unfiltered: the synchroniser output feeds the decoder directly.
  always_comb begin
    phase = sync_q[1];
    valid = warm_q[WARM_LEN-1];
  end

`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top level: conditions A/B, tracks the previous phase,
// and turns Gray transitions into a modular position count, a direction
// flag, a one-cycle step pulse and a sticky illegal-transition flag.
// Optional glitch filter: define QUAD_DECODER_FILTER_EN.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic          clk,
  input  logic          reset,
  quad_decoder_if.slave bus
);

  logic a_ph, b_ph;
  logic a_valid, b_valid;

  quad_input_cond #(.FILT_LEN(FILT_LEN)) u_cond_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.a_in),
    .phase (a_ph),
    .valid (a_valid)
  );

  quad_input_cond #(.FILT_LEN(FILT_LEN)) u_cond_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.b_in),
    .phase (b_ph),
    .valid (b_valid)
  );

  phase_t           ph;
  move_t            move;
  state_t           state_q, state_d;
  phase_t           prev_q,  prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             up_q,    up_d;
  logic             step_q,  step_d;
  logic             err_q,   err_d;
  logic             dbl;

  assign ph = phase_t'({a_ph, b_ph});

  // Classify the current phase against the last accepted one.
  always_comb move = classify(prev_q, ph);

  // Next-state logic: priming, step decode, then clear overrides.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    prev_d  = prev_q;
    count_d = count_q;
    up_d    = up_q;
    step_d  = 1'b0;
    err_d   = err_q;
    dbl     = 1'b0;

    case (state_q)
      ST_WAIT: begin
        // First real phase pair only seeds prev; nothing is counted.
        if (a_valid && b_valid) begin
          prev_d  = ph;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        // prev follows the pins even while disabled, so re-enabling
        // cannot produce a spurious step.
        prev_d = ph;
        if (bus.en) begin
          case (move)
            MOVE_FWD: begin
              count_d = count_q + 1'b1;
              up_d    = DIR_UP;
              step_d  = 1'b1;
            end
            MOVE_REV: begin
              count_d = count_q - 1'b1;
              up_d    = DIR_DN;
              step_d  = 1'b1;
            end
            MOVE_BAD: dbl = 1'b1;
            default:  ;
          endcase
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Clear beats a simultaneous step; direction still records the step.
    if (bus.clr) begin
      count_d = '0;
      step_d  = 1'b0;
    end

    // A new illegal transition beats a simultaneous error clear.
    if (dbl) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // State register for the decoder, counter and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      prev_q  <= PH_00;
      count_q <= '0;
      up_q    <= DIR_UP;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      up_q    <= up_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.up    = up_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios with literal expectations,
// then randomized encoder traffic, with a sample-history reference model
// compared against the outputs after every rising edge.
// Honours QUAD_DECODER_FILTER_EN the same way the design does.
module tb_quad_decoder;
  import quad_decoder_pkg::*;

  localparam int WIDTH    = 16;
  localparam int FILT_LEN = 3;
`ifdef QUAD_DECODER_FILTER_EN
  localparam int LAT  = FILT_LEN + 2;  // edges from pin change to output
  localparam int HOLD = FILT_LEN + 1;  // minimum safe phase hold time
`else
  localparam int LAT  = 3;
  localparam int HOLD = 3;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  quad_decoder_if #(.WIDTH(WIDTH)) bus ();

  quad_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass     = 0;
  int n_total    = 0;
  int steps_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit               sa[$], sb[$];   // pin samples since reset, oldest first
  int               k;              // rising edges since reset release
  bit               m_primed;
  logic [1:0]       m_prev;
  logic [WIDTH-1:0] m_count;
  logic             m_up, m_step, m_err;
  bit               fa_ok, fb_ok;
  logic             fa_val, fb_val;

  // Position of a phase along the forward cycle 00,01,11,10.
  function automatic int gpos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // True if the last FILT_LEN samples seen by the decoder agree.
  function automatic bit win_stable(input bit sel_b);
    bit ref_v;
    ref_v = sel_b ? sb[k-3] : sa[k-3];
    for (int j = k - FILT_LEN - 2; j <= k - 3; j++) begin
      if ((sel_b ? sb[j] : sa[j]) != ref_v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    sa.delete(); sb.delete();
    k = 0; m_primed = 0; m_prev = 2'b00;
    m_count = '0; m_up = 1'b1; m_step = 1'b0; m_err = 1'b0;
    fa_ok = 0; fb_ok = 0; fa_val = 1'b0; fb_val = 1'b0;
  endtask

  task automatic model_edge(input logic a, input logic b, input logic en,
                            input logic clr, input logic eclr);
    logic [1:0] ph;
    bit         ok, dbl;
    int         d;
    k++;
    sa.push_back(a);
    sb.push_back(b);
    m_step = 1'b0;
    dbl    = 0;
    ph     = 2'b00;
`ifdef QUAD_DECODER_FILTER_EN
    if (k >= FILT_LEN + 2) begin
      if (win_stable(1'b0)) begin fa_val = sa[k-3]; fa_ok = 1; end
      if (win_stable(1'b1)) begin fb_val = sb[k-3]; fb_ok = 1; end
    end
    ok = fa_ok && fb_ok;
    ph = {fa_val, fb_val};
`else
    ok = (k >= 3);
    if (ok) ph = {sa[k-3], sb[k-3]};
`endif
    if (ok) begin
      if (!m_primed) begin
        m_primed = 1;
      end else if (en) begin
        d = (gpos(ph) - gpos(m_prev) + 4) % 4;
        if (d == 1)      begin m_count = m_count + 1'b1; m_up = 1'b1; m_step = 1'b1; end
        else if (d == 3) begin m_count = m_count - 1'b1; m_up = 1'b0; m_step = 1'b1; end
        else if (d == 2) dbl = 1;
      end
      m_prev = ph;
    end
    if (clr) begin m_count = '0; m_step = 1'b0; end
    if (dbl) m_err = 1'b1;
    else if (eclr) m_err = 1'b0;
  endtask

  // Compare process: advance the model on each edge, check just after it.
  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_edge(bus.a_in, bus.b_in, bus.en, bus.clr, bus.err_clr);
    #1;
    check("cycle", {bus.count, bus.up, bus.step, bus.err}, {m_count, m_up, m_step, m_err});
    if (bus.step === 1'b1) steps_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ph(input logic [1:0] p);
    @(negedge clk);
    bus.a_in = p[1];
    bus.b_in = p[0];
  endtask

  task automatic move_to(input logic [1:0] p);
    set_ph(p);
    repeat (LAT + 3) @(negedge clk);
  endtask

  function automatic logic [1:0] rev_of(input logic [1:0] p);
    logic [1:0] q;
    for (int i = 0; i < 4; i++) begin
      q = i[1:0];
      if (next_fwd(phase_t'(q)) == phase_t'(p)) return q;
    end
    return p;
  endfunction

  int s0;

  initial begin
    bus.a_in = 1'b1; bus.b_in = 1'b1;
    bus.en = 1'b1; bus.clr = 1'b0; bus.err_clr = 1'b0;
    #12;
    check("rst_count", bus.count, 0);
    check("rst_up",    bus.up,    1);
    check("rst_step",  bus.step,  0);
    check("rst_err",   bus.err,   0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    check("prime_count", bus.count, 0);
    check("prime_err",   bus.err,   0);
    check("prime_steps", steps_seen, 0);

    move_to(2'b10);
    check("first_count", bus.count, 1);
    check("first_up",    bus.up,    1);

    @(negedge clk) bus.clr = 1'b1;
    @(negedge clk) bus.clr = 1'b0;
    check("clr_count", bus.count, 0);

    s0 = steps_seen;
    move_to(2'b00); move_to(2'b01); move_to(2'b11); move_to(2'b10);
    check("fwd4_count", bus.count, 4);
    check("fwd4_up",    bus.up,    1);
    check("fwd4_steps", steps_seen - s0, 4);
    move_to(2'b11); move_to(2'b01); move_to(2'b00); move_to(2'b10);
    check("rev4_count", bus.count, 0);
    check("rev4_up",    bus.up,    0);

    move_to(2'b11);
    check("wrap_dn", bus.count, 16'hFFFF);
    move_to(2'b10);
    check("wrap_up", bus.count, 0);

    move_to(2'b01);
    check("dbl_err",   bus.err,   1);
    check("dbl_count", bus.count, 0);
    @(negedge clk) bus.err_clr = 1'b1;
    @(negedge clk) bus.err_clr = 1'b0;
    check("err_clr", bus.err, 0);

    set_ph(2'b10);
    repeat (LAT - 1) @(negedge clk);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    check("err_set_wins", bus.err, 1);
    @(negedge clk) bus.err_clr = 1'b0;
    check("err_sticky", bus.err, 1);

    move_to(2'b00); move_to(2'b01);
    check("pre_clr_count", bus.count, 2);
    set_ph(2'b11);
    repeat (LAT - 2) @(negedge clk);
    @(posedge clk); #1;
    check("clr_early_step", bus.step, 0);
    @(negedge clk) bus.clr = 1'b1;
    @(posedge clk); #1;
    check("clr_wins_step",  bus.step,  0);
    check("clr_wins_count", bus.count, 0);
    @(negedge clk) bus.clr = 1'b0;

    set_ph(2'b10);
    repeat (LAT - 2) @(negedge clk);
    @(posedge clk); #1;
    check("lat_early", bus.step, 0);
    @(posedge clk); #1;
    check("lat_step",  bus.step,  1);
    check("lat_count", bus.count, 1);

    @(negedge clk) bus.en = 1'b0;
    s0 = steps_seen;
    move_to(2'b00); move_to(2'b01); move_to(2'b11);
    check("en0_count", bus.count, 1);
    @(negedge clk) bus.en = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    check("en1_no_spurious", steps_seen - s0, 0);
    move_to(2'b10);
    check("en1_count", bus.count, 2);

`ifdef QUAD_DECODER_FILTER_EN
    s0 = steps_seen;
    @(negedge clk) bus.a_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.a_in = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("glitch_steps", steps_seen - s0, 0);
    check("glitch_count", bus.count, 2);
`endif

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_err",   bus.err,   0);
    @(negedge clk) reset = 1'b1;
    repeat (LAT + 5) @(negedge clk);

    for (int i = 0; i < 700; i++) begin
      int         r;
      int         hold;
      logic [1:0] cur, nxt;
      cur = {bus.a_in, bus.b_in};
      r   = $urandom_range(0, 99);
      if (r < 55)      nxt = next_fwd(phase_t'(cur));
      else if (r < 85) nxt = rev_of(cur);
      else if (r < 92) nxt = ~cur;
      else             nxt = cur;
      if ($urandom_range(0, 19) == 0) hold = $urandom_range(1, HOLD);
      else                            hold = $urandom_range(HOLD, HOLD + 5);
      @(negedge clk);
      bus.a_in    = nxt[1];
      bus.b_in    = nxt[0];
      bus.en      = ($urandom_range(0, 9) != 0);
      bus.clr     = bus.en && ($urandom_range(0, 29) == 0);
      bus.err_clr = bus.en && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      bus.clr     = 1'b0;
      bus.err_clr = 1'b0;
      repeat (hold - 1) @(negedge clk);
    end

    bus.en = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that turns the two phase signals of an incremental encoder (A/B) into direction and position. It is the receiving end of the up/down counting path: it derives `up` and the count steps from the encoder waveform itself instead of taking them as a direction input. It sits between the encoder input pins and the position/control logic, and adds input synchronisation, optional glitch filtering, and illegal-transition detection.

## Interface
- `WIDTH`, 16: position counter width in bits.
- `FILT_LEN`, 3: consecutive stable cycles needed to accept a new A/B value. Used only when the filter is compiled in. Range 2..15.

- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `a_in`  input  1  encoder phase A, asynchronous to `clk`.
- `b_in`  input  1  encoder phase B, asynchronous to `clk`.
- `en`  input  1  count enable. When 0, count is frozen but phase tracking continues.
- `clr`  input  1  synchronous clear of `count`.
- `err_clr`  input  1  synchronous clear of `err`.
- `count`  output  WIDTH  position, two's-complement modular.
- `up`  output  1  direction of the last valid step (1 = up).
- `step`  output  1  one-cycle pulse on each counted step.
- `err`  output  1  sticky flag for an illegal (double) phase transition.

## Operation
- A and B each pass through a 2-FF synchroniser, then the optional filter, giving the phase pair `ph = {a,b}`.
- `prev` holds the last accepted `ph`. A `primed` flag is cleared by reset.
- First accepted sample after reset: load `prev`. No count, no `step`, no `err`. Then set `primed`.
- Forward (up) Gray sequence: 00→01→11→10→00. The reverse sequence is down.
- Each cycle with `primed=1`, compare `ph` with `prev`:
  - Equal: no action.
  - One bit differs, forward order: `count+1`, `up=1`, `step=1`.
  - One bit differs, reverse order: `count-1`, `up=0`, `step=1`.
  - Both bits differ: `err=1`. `count`, `up` and `step` are unchanged.
  - `prev<=ph` in every case.
- `count` wraps modulo 2^WIDTH: all-ones +1 → 0, and 0 −1 → all-ones.
- `en=0`: `prev` still tracks, so re-enabling causes no spurious step. `count`, `up`, `step` and `err` hold their previous values, with `step=0`.
- `clr=1`: `count<=0` and `step=0`. `clr` wins over a simultaneous step. `up` and `prev` are unaffected.
- `err_clr=1`: `err<=0`, unless a double transition occurs in the same cycle, in which case set wins.

## Timing
- Reset values: `count=0`, `up=1`, `step=0`, `err=0`, `prev=00`, `primed=0`, synchroniser and filter flops 0.
- Reset is asynchronous assert, synchronous-safe deassert. Reset asserted mid-operation clears all state immediately.
- Latency without the filter: an input change is visible in `count`/`step` after the 3rd rising edge (2 sync + 1 decode).
- Latency with the filter: 3 + FILT_LEN − 1 edges.
- `step` is high for exactly one cycle per counted step.
- Maximum input rate: one phase change per 3 cycles (filter out) or per FILT_LEN+1 cycles (filter in). Faster changes may alias into `err`.

## Configuration
- `QUAD_DECODER_FILTER_EN` defined:
  - Each synchronised bit is accepted only after it has been stable for FILT_LEN consecutive cycles.
  - Shorter pulses are discarded entirely.
- Macro undefined:
  - The synchroniser output feeds the decoder directly.
  - FILT_LEN is ignored, and no filter flops exist.

## Structure
- Package `quad_decoder_pkg` holds:
  - `phase_t` (2-bit Gray state) with the four named values.
  - Direction constants `DIR_UP=1` and `DIR_DN=0`.
  - A function `next_fwd(phase_t)` used by both the RTL and the bench.
- Sub-module `quad_input_cond`: one instance per phase, containing the 2-FF synchroniser plus the filter when compiled in.
- The top level contains the decode logic, `prev`/`primed`, the counter and `err`.

## Test plan
- Reset with A=1,B=1 held, then release → no `step`, no `err`, `count=0`. The next change to 10 gives `count=1`, `up=1`.
- Four forward edges 00→01→11→10→00 → four `step` pulses, `count=4`, `up=1`. Then four reverse edges → `count=0`, `up=0`.
- Start at `count=0` and take one reverse step → `count=2^WIDTH−1`. One forward step → `count=0`.
- Change A and B together (00→11) → `err=1`, `count` unchanged. Assert `err_clr` alone → `err=0`. Assert `err_clr` together with a new double transition → `err` stays 1.
- `clr` in the same cycle as a forward step → `count=0`, `step=0`. With `en=0`, toggle through 3 steps → `count` frozen. Set `en=1` → no spurious step.
- With `QUAD_DECODER_FILTER_EN` and FILT_LEN=3, a 2-cycle glitch on A → no `step`. A 3-cycle-stable change → exactly one `step`, arriving 5 edges after the input change.
